jk_excitation_driver: RTL and testbench
=======================================

Name: jk_excitation_driver

Overview:
- Drives the J/K inputs of a downstream jk_flipflop so that its Q follows a requested target bit stream.
- Reads the flop's Q back, compares it against an internal state model, and flags any mismatch.
- Counts mismatches in a saturating error counter.
- Sits between a target-bit producer (valid/ready) and the flip-flop: the excitation end of the JK interface.

Parameters:
- CNT_W, 8: width of the saturating mismatch counter err_cnt.
- RESYNC, 1: 1 = load the model from q_obs on mismatch; 0 = the model keeps the target value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- tgt_valid  input  1  target bit offered.
- tgt_bit  input  1  requested next Q value.
- tgt_ready  output  1  block can accept a target.
- j  output  1  registered J drive to the flop.
- k  output  1  registered K drive to the flop.
- q_obs  input  1  Q observed from the flop.
- busy  output  1  high while in DRIVE or CHECK.
- mismatch  output  1  one-cycle pulse when q_obs differs from the model.
- err_cnt  output  CNT_W  saturating mismatch count.

Behaviour:
- Reset, sampled at the rising edge with rst=1:
  - state=IDLE, q_model=0, j=0, k=0, mismatch=0, err_cnt=0.
  - tgt_ready=1 and busy=0 once in IDLE. Both are combinational from state.
- The downstream flop is reset together with this block, so its reset value of Q=0 matches q_model.
- FSM, three states, one target per 3 cycles:
  - IDLE: tgt_ready=1, j=k=0. On tgt_valid&tgt_ready, register {j,k}=excite(q_model, tgt_bit), latch tgt_bit into tgt_r, go to DRIVE.
  - DRIVE: j/k held stable. The flop samples them at the edge leaving DRIVE. On that edge: j=k=0, q_model=tgt_r, go to CHECK.
  - CHECK: q_obs is valid this cycle. At the edge leaving CHECK, go to IDLE and:
    - if q_obs!=q_model: mismatch=1 for one cycle, err_cnt+=1 unless already all-ones (saturates), and q_model=q_obs if RESYNC=1;
    - otherwise mismatch=0.
- Latency: accept edge to mismatch visible = 2 edges. The next accept is possible at the edge after CHECK.
- Default excitation, no toggle, with don't-cares resolved to 0:
  - 0->0: J=0 K=0
  - 0->1: J=1 K=0
  - 1->0: J=0 K=1
  - 1->1: J=0 K=0
- J=K=1 is never driven in default mode.
- tgt_valid is ignored while busy. tgt_bit is only sampled on an accept.
- rst in any state returns to reset values at that edge. An in-flight target is dropped with no mismatch, and j/k are forced to 0 on the same edge.
- q_obs is ignored outside CHECK.
- err_cnt saturates at 2^CNT_W-1. Further mismatches still pulse mismatch.

Optional Feature:
- Macro: JK_DRV_TOGGLE_EN.
- Defined: every state-changing transition uses toggle, J=K=1, for both 0->1 and 1->0. Hold cases are unchanged (0,0). This exercises the flop's toggle path.
- Undefined: the set/reset table above is used, and J=K=1 never occurs.
- FSM timing and checking are identical in both builds.

Decomposition:
- Package jk_drv_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_CHECK=2'd2;
  - excitation code constants EXC_HOLD, EXC_SET, EXC_RST, EXC_TOG as 2-bit {J,K}.
- One sub-module, jk_excite_map: purely combinational. Inputs (q_cur, q_next), output {j,k}. It contains the JK_DRV_TOGGLE_EN selection.
- The FSM, model and counter stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles then 0 -> j=k=0, err_cnt=0, mismatch=0, tgt_ready=1, busy=0.
- Sequence 1,1,0,0,1 sent back-to-back to a real jk_flipflop:
  - j/k during DRIVE: (1,0),(0,0),(0,1),(0,0),(1,0);
  - q_obs follows 1,1,0,0,1;
  - mismatch never asserted, err_cnt=0;
  - tgt_ready low for exactly 2 cycles after each accept.
- Fault injection: force q_obs=0 during CHECK after target 1 -> mismatch pulse 1 cycle, err_cnt=1, q_model=0 (RESYNC=1). The next target 1 drives j=1 again.
- Saturation: CNT_W=2 with 5 forced mismatches -> err_cnt goes 1,2,3,3,3, and mismatch pulses all 5 times.
- Mid-operation reset: assert rst in DRIVE -> next edge j=k=0 and state IDLE, no mismatch, and the target is not retried.
- JK_DRV_TOGGLE_EN defined, sequence 1,0 -> j=k=1 in both DRIVE cycles, q_obs 1 then 0, no mismatch.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared types and {J,K} excitation codes for the JK excitation driver.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } drv_state_t;

  // Codes are packed as {J,K}.
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_RST  = 2'b01;
  localparam logic [1:0] EXC_TOG  = 2'b11;

endpackage

// File: rtl/jk_excite_map.sv
// Combinational {J,K} excitation for a current->next Q transition.
// Define JK_DRV_TOGGLE_EN to drive every state change with the toggle code.
module jk_excite_map
  import jk_drv_pkg::*;
(
  input  logic       q_cur,
  input  logic       q_next,
  output logic [1:0] jk
);

  always_comb begin
    jk = EXC_HOLD;
    if (q_cur != q_next) begin
`ifdef JK_DRV_TOGGLE_EN
      jk = EXC_TOG;
`else
      jk = q_next ? EXC_SET : EXC_RST;
`endif
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flop so Q tracks a target stream, checks Q against a model and
// counts mismatches (saturating). Optional build macro: JK_DRV_TOGGLE_EN.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int RESYNC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             j,
  output logic             k,
  input  logic             q_obs,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  drv_state_t       state_q, state_d;
  logic             q_model, q_model_d;
  logic             tgt_r, tgt_d;
  logic             j_d, k_d, mismatch_d;
  logic [CNT_W-1:0] err_d;
  logic [1:0]       exc_jk;

  jk_excite_map u_map (
    .q_cur  (q_model),
    .q_next (tgt_bit),
    .jk     (exc_jk)
  );

  assign tgt_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);

  always_comb begin
    state_d    = state_q;
    q_model_d  = q_model;
    tgt_d      = tgt_r;
    j_d        = 1'b0;
    k_d        = 1'b0;
    mismatch_d = 1'b0;
    err_d      = err_cnt;
    case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          {j_d, k_d} = exc_jk;
          tgt_d      = tgt_bit;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // The flop samples J/K on this same edge, so the model advances with it.
        q_model_d = tgt_r;
        state_d   = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (q_obs != q_model) begin
          mismatch_d = 1'b1;
          if (err_cnt != '1) err_d = err_cnt + 1'b1;
          if (RESYNC != 0) q_model_d = q_obs;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_model  <= 1'b0;
      tgt_r    <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      q_model  <= q_model_d;
      tgt_r    <= tgt_d;
      j        <= j_d;
      k        <= k_d;
      mismatch <= mismatch_d;
      err_cnt  <= err_d;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver driving a behavioural JK flop,
// with a scoreboard of expected per-target results.
module tb_jk_excitation_driver;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             tgt_valid;
  logic             tgt_bit;
  logic             tgt_ready;
  logic             j, k;
  logic             q_obs;
  logic             busy;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;

  logic             flop_q;
  logic             q_force;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]       jk;
    logic             obs;
    logic             mm;
    logic [CNT_W-1:0] err;
  } sb_t;
  sb_t sb[$];

  // Bench-side model state.
  logic             m_q;
  logic             m_fq;
  logic [CNT_W-1:0] m_err;

  jk_excitation_driver #(.CNT_W(CNT_W), .RESYNC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_bit   (tgt_bit),
    .tgt_ready (tgt_ready),
    .j         (j),
    .k         (k),
    .q_obs     (q_obs),
    .busy      (busy),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Downstream JK flop, reset together with the driver.
  always_ff @(posedge clk) begin
    if (rst) flop_q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   flop_q <= 1'b1;
        2'b01:   flop_q <= 1'b0;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end

  assign q_obs = q_force ? 1'b0 : flop_q;

  function automatic logic [1:0] exc_model(input logic q, input logic t);
    if (q == t) return 2'b00;
`ifdef JK_DRV_TOGGLE_EN
    return 2'b11;
`else
    return t ? 2'b10 : 2'b01;
`endif
  endfunction

  function automatic logic flop_model(input logic q, input logic [1:0] jk);
    case (jk)
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q   = 1'b0;
    m_fq  = 1'b0;
    m_err = '0;
    sb.delete();
  endtask

  // One target through DRIVE/CHECK/result; entered and left at a negedge in IDLE.
  task automatic send(input logic t, input logic bad);
    sb_t e;
    int  n = 0;
    while (!tgt_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 8'(tgt_ready), 8'd1);
    e.jk  = exc_model(m_q, t);
    m_fq  = flop_model(m_fq, e.jk);
    e.obs = bad ? 1'b0 : m_fq;
    e.mm  = (e.obs != t);
    if (e.mm && m_err != '1) m_err = m_err + 1'b1;
    e.err = m_err;
    m_q   = e.mm ? e.obs : t;
    sb.push_back(e);

    tgt_valid = 1'b1;
    tgt_bit   = t;
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_bit   = ~t;
    chk("drive_jk", 8'({j, k}), 8'(sb[0].jk));
    chk("drive_busy", 8'({busy, tgt_ready}), 8'b10);
    chk("drive_mm", 8'(mismatch), 8'd0);
    q_force = bad;
    @(negedge clk);
    chk("check_jk", 8'({j, k}), 8'd0);
    chk("check_ready", 8'(tgt_ready), 8'd0);
    chk("check_qobs", 8'(q_obs), 8'(sb[0].obs));
    @(negedge clk);
    q_force = 1'b0;
    e = sb.pop_front();
    chk("result_mm", 8'(mismatch), 8'(e.mm));
    chk("result_err", 8'(err_cnt), 8'(e.err));
    chk("result_ready", 8'({busy, tgt_ready}), 8'b01);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_jk", 8'({j, k}), 8'd0);
    chk("rst_err", 8'(err_cnt), 8'd0);
    chk("rst_mm", 8'(mismatch), 8'd0);
    chk("rst_ready_busy", 8'({tgt_ready, busy}), 8'b10);
  endtask

  initial begin
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_bit   = 1'b0;
    q_force   = 1'b0;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // Back-to-back sequence through the flop.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);

    // Forced mismatch, then resynced model drives a set again.
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);

    // Counter saturation.
    pulse_reset();
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1);

    // Reset while in DRIVE drops the target.
    pulse_reset();
    tgt_valid = 1'b1;
    tgt_bit   = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("mid_drive_jk", 8'({j, k}), 8'(exc_model(1'b0, 1'b1)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mid_rst_jk", 8'({j, k}), 8'd0);
    chk("mid_rst_state", 8'({tgt_ready, busy, mismatch}), 8'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_retry", 8'({busy, mismatch, err_cnt}), 8'd0);
    end

    // Opposite transitions (toggle path when JK_DRV_TOGGLE_EN is defined).
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
